// File: rtl/seq_pattern_tx_if.sv
// rtl/seq_pattern_tx_if.sv - control and serial-output bundle for seq_pattern_tx
// The master drives start/abort/repeat_cnt; the slave (the transmitter) drives the serial side.
interface seq_pattern_tx_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic [CNT_W-1:0] repeat_cnt;
  logic             abort;
  logic             dataout;
  logic             bit_valid;
  logic             busy;
  logic             frame_done;

  modport master (
    output start, repeat_cnt, abort,
    input  dataout, bit_valid, busy, frame_done
  );

  modport slave (
    input  start, repeat_cnt, abort,
    output dataout, bit_valid, busy, frame_done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial pattern transmitter, MSB-first, with repeat count and idle gap
// Every output is a flop; the first bit is registered on the same edge that accepts start.
module seq_pattern_tx #(
  parameter int             PAT_W   = 5,
  parameter logic [PAT_W-1:0] PATTERN = 5'b11101,
  parameter int             CNT_W   = 4,
  parameter int             GAP_CYC = 0
) (
  input  logic          clock,
  input  logic          reset,
  seq_pattern_tx_if.slave tx
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] ONE_REP  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] sreg_q, sreg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] reps_q, reps_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             dataout_q, dataout_d;
  logic             bit_valid_q, bit_valid_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;

  logic             do_load;
  logic [CNT_W-1:0] reps_dec;

  // Saturating decrement: reps never wraps below zero.
  assign reps_dec = (reps_q == '0) ? '0 : reps_q - ONE_REP;

  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    idx_d        = idx_q;
    reps_d       = reps_q;
    gap_d        = gap_q;
    dataout_d    = 1'b0;
    bit_valid_d  = 1'b0;
    busy_d       = 1'b0;
    frame_done_d = 1'b0;
    do_load      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (tx.start) begin
          reps_d  = (tx.repeat_cnt == '0) ? ONE_REP : tx.repeat_cnt;
          do_load = 1'b1;
        end
      end

      S_SHIFT: begin
        if (tx.abort) begin
          state_d = S_IDLE;
          idx_d   = '0;
          reps_d  = '0;
          gap_d   = '0;
        end else if (idx_q != LAST_IDX) begin
          idx_d       = idx_q + IDX_W'(1);
          dataout_d   = sreg_q[PAT_W-1];
          sreg_d      = sreg_q << 1;
          bit_valid_d = 1'b1;
          busy_d      = 1'b1;
        end else begin
          reps_d = reps_dec;
          if (reps_dec != '0) begin
            if (GAP_CYC > 0) begin
              state_d = S_GAP;
              gap_d   = GAP_LOAD;
              idx_d   = '0;
              busy_d  = 1'b1;
            end else begin
              do_load = 1'b1;
            end
          end else begin
            state_d      = S_IDLE;
            idx_d        = '0;
            frame_done_d = 1'b1;
          end
        end
      end

      S_GAP: begin
        if (tx.abort) begin
          state_d = S_IDLE;
          reps_d  = '0;
          gap_d   = '0;
        end else if (gap_q == '0) begin
          do_load = 1'b1;
        end else begin
          gap_d  = gap_q - GAP_W'(1);
          busy_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A load emits the pattern MSB on this edge; sreg keeps the bits still to go.
    if (do_load) begin
      state_d     = S_SHIFT;
      sreg_d      = PATTERN << 1;
      idx_d       = '0;
      dataout_d   = PATTERN[PAT_W-1];
      bit_valid_d = 1'b1;
      busy_d      = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sreg_q       <= '0;
      idx_q        <= '0;
      reps_q       <= '0;
      gap_q        <= '0;
      dataout_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      idx_q        <= idx_d;
      reps_q       <= reps_d;
      gap_q        <= gap_d;
      dataout_q    <= dataout_d;
      bit_valid_q  <= bit_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx.dataout    = dataout_q;
  assign tx.bit_valid  = bit_valid_q;
  assign tx.busy       = busy_q;
  assign tx.frame_done = frame_done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - directed bench for seq_pattern_tx, back-to-back and gapped instances
// Each capture records one bit per cycle, first cycle in the MSB of the used width.
module tb_seq_pattern_tx;

  logic clock;
  logic reset;

  seq_pattern_tx_if #(.CNT_W(4)) if0 ();
  seq_pattern_tx_if #(.CNT_W(4)) if2 ();

  seq_pattern_tx #(.PAT_W(5), .PATTERN(5'b11101), .CNT_W(4), .GAP_CYC(0)) dut0 (
    .clock (clock),
    .reset (reset),
    .tx    (if0)
  );

  seq_pattern_tx #(.PAT_W(5), .PATTERN(5'b11101), .CNT_W(4), .GAP_CYC(2)) dut2 (
    .clock (clock),
    .reset (reset),
    .tx    (if2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic capture(input int which, input int n, input logic [31:0] st, input logic [31:0] ab,
                         output logic [31:0] dov, output logic [31:0] dvv,
                         output logic [31:0] bsv, output logic [31:0] fdv);
    dov = '0;
    dvv = '0;
    bsv = '0;
    fdv = '0;
    for (int j = 0; j < n; j++) begin
      if (which == 0) begin
        if0.start = st[n-1-j];
        if0.abort = ab[n-1-j];
      end else begin
        if2.start = st[n-1-j];
        if2.abort = ab[n-1-j];
      end
      @(posedge clock);
      #1;
      if (which == 0) begin
        dov = {dov[30:0], if0.dataout};
        dvv = {dvv[30:0], if0.bit_valid};
        bsv = {bsv[30:0], if0.busy};
        fdv = {fdv[30:0], if0.frame_done};
      end else begin
        dov = {dov[30:0], if2.dataout};
        dvv = {dvv[30:0], if2.bit_valid};
        bsv = {bsv[30:0], if2.busy};
        fdv = {fdv[30:0], if2.frame_done};
      end
    end
    if0.start = 1'b0;
    if0.abort = 1'b0;
    if2.start = 1'b0;
    if2.abort = 1'b0;
  endtask

  logic [31:0] dov, dvv, bsv, fdv;
  logic [4:0]  win;
  int          hits;

  initial begin
    reset = 1'b1;
    if0.start = 1'b0;  if0.abort = 1'b0;  if0.repeat_cnt = 4'd1;
    if2.start = 1'b0;  if2.abort = 1'b0;  if2.repeat_cnt = 4'd1;

    repeat (3) @(posedge clock);
    #1;
    check("rst_dataout", {31'd0, if0.dataout}, 32'd0);
    check("rst_valid", {31'd0, if0.bit_valid}, 32'd0);
    check("rst_busy", {31'd0, if0.busy}, 32'd0);
    check("rst_done", {31'd0, if0.frame_done}, 32'd0);
    check("rst_busy_gap", {31'd0, if2.busy}, 32'd0);
    reset = 1'b0;

    capture(0, 10, 32'd0, 32'd0, dov, dvv, bsv, fdv);
    check("idle_dataout", dov, 32'd0);
    check("idle_busy", bsv, 32'd0);
    check("idle_done", fdv, 32'd0);

    if0.repeat_cnt = 4'd1;
    capture(0, 7, 32'b1000000, 32'd0, dov, dvv, bsv, fdv);
    check("single_data", dov, 32'b1110100);
    check("single_valid", dvv, 32'b1111100);
    check("single_busy", bsv, 32'b1111100);
    check("single_done", fdv, 32'b0000010);

    if0.repeat_cnt = 4'd3;
    capture(0, 17, 32'b1 << 16, 32'd0, dov, dvv, bsv, fdv);
    check("rep3_data", dov, 32'b11101111011110100);
    check("rep3_valid", dvv, 32'b11111111111111100);
    check("rep3_busy", bsv, 32'b11111111111111100);
    check("rep3_done", fdv, 32'b00000000000000010);
    win  = '0;
    hits = 0;
    for (int j = 16; j >= 0; j--) begin
      if (dvv[j]) begin
        win = {win[3:0], dov[j]};
        if (win == 5'b11101) hits++;
      end
    end
    check("rep3_detector_hits", hits, 32'd3);

    if2.repeat_cnt = 4'd2;
    capture(1, 14, 32'b1 << 13, 32'd0, dov, dvv, bsv, fdv);
    check("gap_data", dov, 32'b11101001110100);
    check("gap_valid", dvv, 32'b11111001111100);
    check("gap_busy", bsv, 32'b11111111111100);
    check("gap_done", fdv, 32'b00000000000010);

    if2.repeat_cnt = 4'd0;
    capture(1, 7, 32'b1000000, 32'd0, dov, dvv, bsv, fdv);
    check("zero_data", dov, 32'b1110100);
    check("zero_busy", bsv, 32'b1111100);
    check("zero_done", fdv, 32'b0000010);

    if0.repeat_cnt = 4'd4;
    capture(0, 10, 32'b1010000010, 32'b0000000100, dov, dvv, bsv, fdv);
    check("abort_data", dov, 32'b1110111011);
    check("abort_valid", dvv, 32'b1111111011);
    check("abort_busy", bsv, 32'b1111111011);
    check("abort_done", fdv, 32'd0);
    capture(0, 2, 32'd0, 32'b10, dov, dvv, bsv, fdv);
    check("abort2_busy", bsv, 32'd0);
    check("abort2_done", fdv, 32'd0);

    if2.repeat_cnt = 4'd2;
    capture(1, 6, 32'b100000, 32'b000001, dov, dvv, bsv, fdv);
    check("gap_abort_busy", bsv, 32'b111110);
    check("gap_abort_done", fdv, 32'd0);

    if0.repeat_cnt = 4'd1;
    capture(0, 13, 32'b1000001000000, 32'd0, dov, dvv, bsv, fdv);
    check("chain_data", dov, 32'b1110101110100);
    check("chain_valid", dvv, 32'b1111101111100);
    check("chain_done", fdv, 32'b0000010000010);

    if0.repeat_cnt = 4'd3;
    capture(0, 3, 32'b100, 32'd0, dov, dvv, bsv, fdv);
    check("prerst_data", dov, 32'b111);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_busy", {31'd0, if0.busy}, 32'd0);
    check("async_rst_valid", {31'd0, if0.bit_valid}, 32'd0);
    check("async_rst_data", {31'd0, if0.dataout}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    capture(0, 3, 32'd0, 32'd0, dov, dvv, bsv, fdv);
    check("postrst_done", fdv, 32'd0);
    check("postrst_busy", bsv, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
